// File: rtl/arx_clock_reset_sequencer_if.sv
// Sequencer-to-platform signal bundle: PLL lock in, warm-reset handshake, domain controls out.
// Latency: none (pure wiring container).
// Backpressure: none; sw_rst_req is a single-cycle request, acknowledged by a single-cycle sw_rst_ack.
interface arx_clock_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       rstnn_dram;
    logic       rstnn_system;
    logic       clken_system;
    logic       ready;
    logic       lock_lost;
    logic [2:0] state;

    // Sequencer side
    modport master (
        input  pll_locked,
        input  sw_rst_req,
        output sw_rst_ack,
        output rstnn_dram,
        output rstnn_system,
        output clken_system,
        output ready,
        output lock_lost,
        output state
    );

    // Platform side (PLL wrapper / software reset source / consumers)
    modport slave (
        output pll_locked,
        output sw_rst_req,
        input  sw_rst_ack,
        input  rstnn_dram,
        input  rstnn_system,
        input  clken_system,
        input  ready,
        input  lock_lost,
        input  state
    );
endinterface

// File: rtl/arx_clock_reset_sequencer.sv
// Releases DRAM reset, then system clock enable, then system reset after a stable PLL lock; services warm resets.
// Latency: lock decisions lag pll_locked by 2 sync edges; all outputs registered with the state they belong to.
// Backpressure: none; sw_rst_req outside RUN is dropped, a request during SW_RST does not extend it.
module arx_clock_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int SYS_RST_DELAY      = 4,
    parameter int SW_RST_CYCLES      = 8,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                         clk,
    input  logic                         rstnn,
    arx_clock_reset_sequencer_if.master  seq
);

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_STABLE    = 3'd1;
    localparam logic [2:0] ST_REL_DRAM  = 3'd2;
    localparam logic [2:0] ST_REL_CLK   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_SW_RST    = 3'd5;

    localparam logic [CNT_WIDTH-1:0] LOCK_RELOAD = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SYS_RELOAD  = CNT_WIDTH'(SYS_RST_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] SW_RELOAD   = CNT_WIDTH'(SW_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic [1:0]           lk_sync;
    logic                 lk;
    logic [2:0]           state_q;
    logic [2:0]           state_nxt;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 cnt_zero;
    logic                 lost_q;
    logic                 lost_nxt;
    logic                 ack_q;
    logic                 ack_nxt;
    logic                 rstnn_dram_q;
    logic                 rstnn_system_q;
    logic                 clken_system_q;
    logic                 ready_q;

    assign lk       = lk_sync[1];
    assign cnt_zero = (cnt_q == '0);

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            lk_sync <= 2'b00;
        end else begin
            lk_sync <= {lk_sync[0], seq.pll_locked};
        end
    end

    // Next-state, counter reload/decrement, sticky lock-loss and ack decode
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        lost_nxt  = lost_q;
        ack_nxt   = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = LOCK_RELOAD;
                end
            end
            ST_STABLE: begin
                // A drop before any reset is released is just a retry, not a lock loss
                if (!lk) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_zero) begin
                    state_nxt = ST_REL_DRAM;
                    cnt_nxt   = SYS_RELOAD;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            ST_REL_DRAM: begin
                if (!lk) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_REL_CLK;
                    cnt_nxt   = SYS_RELOAD;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            ST_REL_CLK: begin
                if (!lk) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                // Lock loss takes priority over a coincident warm-reset request
                if (!lk) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else if (seq.sw_rst_req) begin
                    state_nxt = ST_SW_RST;
                    cnt_nxt   = SW_RELOAD;
                end
            end
            ST_SW_RST: begin
                // Requests arriving here are ignored; an abandoned warm reset is never acked
                if (!lk) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and outputs registered together, outputs decoded from next state
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            lost_q         <= 1'b0;
            ack_q          <= 1'b0;
            rstnn_dram_q   <= 1'b0;
            rstnn_system_q <= 1'b0;
            clken_system_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            cnt_q          <= cnt_nxt;
            lost_q         <= lost_nxt;
            ack_q          <= ack_nxt;
            rstnn_dram_q   <= (state_nxt == ST_REL_DRAM) || (state_nxt == ST_REL_CLK) ||
                              (state_nxt == ST_RUN)      || (state_nxt == ST_SW_RST);
            clken_system_q <= (state_nxt == ST_REL_CLK)  || (state_nxt == ST_RUN) ||
                              (state_nxt == ST_SW_RST);
            rstnn_system_q <= (state_nxt == ST_RUN);
            ready_q        <= (state_nxt == ST_RUN);
        end
    end

    assign seq.state        = state_q;
    assign seq.sw_rst_ack   = ack_q;
    assign seq.lock_lost    = lost_q;
    assign seq.rstnn_dram   = rstnn_dram_q;
    assign seq.rstnn_system = rstnn_system_q;
    assign seq.clken_system = clken_system_q;
    assign seq.ready        = ready_q;

endmodule

// File: tb/tb_arx_clock_reset_sequencer.sv
// Directed bench for the clock/reset sequencer: table of held-input steps plus hand-written corner sequences.
// Latency: cycle numbers below count posedges after rstnn release with pll_locked already high.
// Backpressure: not applicable.
module tb_arx_clock_reset_sequencer;

    logic clk = 1'b0;
    logic rstnn;

    always #5 clk = ~clk;

    arx_clock_reset_sequencer_if dut_if ();
    arx_clock_reset_sequencer_if v_if ();

    arx_clock_reset_sequencer dut (
        .clk   (clk),
        .rstnn (rstnn),
        .seq   (dut_if)
    );

    arx_clock_reset_sequencer #(
        .LOCK_STABLE_CYCLES (1),
        .SYS_RST_DELAY      (1),
        .SW_RST_CYCLES      (8),
        .CNT_WIDTH          (8)
    ) dut_fast (
        .clk   (clk),
        .rstnn (rstnn),
        .seq   (v_if)
    );

    // Observation order: {state[2:0], rstnn_dram, rstnn_system, clken_system, ready, sw_rst_ack, lock_lost}
    logic [8:0] obs_m;
    logic [8:0] obs_v;
    assign obs_m = {dut_if.state, dut_if.rstnn_dram, dut_if.rstnn_system, dut_if.clken_system,
                    dut_if.ready, dut_if.sw_rst_ack, dut_if.lock_lost};
    assign obs_v = {v_if.state, v_if.rstnn_dram, v_if.rstnn_system, v_if.clken_system,
                    v_if.ready, v_if.sw_rst_ack, v_if.lock_lost};

    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt     = 0;

    // Count warm-reset acks of the default instance
    always @(negedge clk) begin
        if (dut_if.sw_rst_ack === 1'b1) ack_cnt++;
    end

    typedef struct {
        string      nm;
        int         n;
        logic       pll;
        logic       req;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] pk(input logic [2:0] st, input logic d, input logic s,
                                      input logic c, input logic r, input logic a, input logic l);
        return {st, d, s, c, r, a, l};
    endfunction

    function automatic vec_t mk(input string nm, input int n, input logic pll, input logic req,
                                input logic [8:0] exp);
        vec_t v;
        v.nm  = nm;
        v.n   = n;
        v.pll = pll;
        v.req = req;
        v.exp = exp;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b (state,dram,sys,clken,ready,ack,lost)", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    initial begin
        // Edge numbers (after rstnn release, pll_locked=1) in the trailing comments
        tbl.push_back(mk("wait_sync",        2, 1'b1, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 0))); // 2
        tbl.push_back(mk("stable_entry",     1, 1'b1, 1'b0, pk(3'd1, 0, 0, 0, 0, 0, 0))); // 3
        tbl.push_back(mk("stable_end",      15, 1'b1, 1'b0, pk(3'd1, 0, 0, 0, 0, 0, 0))); // 18
        tbl.push_back(mk("rel_dram",         1, 1'b1, 1'b0, pk(3'd2, 1, 0, 0, 0, 0, 0))); // 19
        tbl.push_back(mk("rel_dram_end",     3, 1'b1, 1'b0, pk(3'd2, 1, 0, 0, 0, 0, 0))); // 22
        tbl.push_back(mk("rel_clk",          1, 1'b1, 1'b0, pk(3'd3, 1, 0, 1, 0, 0, 0))); // 23
        tbl.push_back(mk("rel_clk_end",      3, 1'b1, 1'b0, pk(3'd3, 1, 0, 1, 0, 0, 0))); // 26
        tbl.push_back(mk("run",              1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 0))); // 27
        tbl.push_back(mk("sw_rst_entry",     1, 1'b1, 1'b1, pk(3'd5, 1, 0, 1, 0, 0, 0))); // 28
        tbl.push_back(mk("sw_rst_end",       7, 1'b1, 1'b0, pk(3'd5, 1, 0, 1, 0, 0, 0))); // 35
        tbl.push_back(mk("sw_ack",           1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 1, 0))); // 36
        tbl.push_back(mk("ack_one_cycle",    1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 0))); // 37
        tbl.push_back(mk("sw_rst2_entry",    1, 1'b1, 1'b1, pk(3'd5, 1, 0, 1, 0, 0, 0))); // 38
        tbl.push_back(mk("req_in_sw_rst",    1, 1'b1, 1'b1, pk(3'd5, 1, 0, 1, 0, 0, 0))); // 39
        tbl.push_back(mk("sw_rst2_end",      6, 1'b1, 1'b0, pk(3'd5, 1, 0, 1, 0, 0, 0))); // 45
        tbl.push_back(mk("sw_ack2",          1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 1, 0))); // 46
        tbl.push_back(mk("run_after_ack2",   1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 0))); // 47
        tbl.push_back(mk("pll_drop_sync",    2, 1'b0, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 0))); // 49
        tbl.push_back(mk("lock_loss_wins",   1, 1'b0, 1'b1, pk(3'd0, 0, 0, 0, 0, 0, 1))); // 50
        tbl.push_back(mk("wait_unlocked",    1, 1'b0, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 1))); // 51
        tbl.push_back(mk("relock_sync",      2, 1'b1, 1'b0, pk(3'd0, 0, 0, 0, 0, 0, 1))); // 53
        tbl.push_back(mk("relock_stable",    1, 1'b1, 1'b0, pk(3'd1, 0, 0, 0, 0, 0, 1))); // 54
        tbl.push_back(mk("relock_stbl_end", 15, 1'b1, 1'b0, pk(3'd1, 0, 0, 0, 0, 0, 1))); // 69
        tbl.push_back(mk("relock_dram",      1, 1'b1, 1'b0, pk(3'd2, 1, 0, 0, 0, 0, 1))); // 70
        tbl.push_back(mk("relock_clk",       4, 1'b1, 1'b0, pk(3'd3, 1, 0, 1, 0, 0, 1))); // 74
        tbl.push_back(mk("req_in_rel_clk",   1, 1'b1, 1'b1, pk(3'd3, 1, 0, 1, 0, 0, 1))); // 75
        tbl.push_back(mk("relock_run",       3, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 1))); // 78
        tbl.push_back(mk("no_queued_req",    1, 1'b1, 1'b0, pk(3'd4, 1, 1, 1, 1, 0, 1))); // 79

        rstnn              = 1'b0;
        dut_if.pll_locked  = 1'b0;
        dut_if.sw_rst_req  = 1'b0;
        v_if.pll_locked    = 1'b0;
        v_if.sw_rst_req    = 1'b0;

        step(2);
        chk("reset_state", obs_m, pk(3'd0, 0, 0, 0, 0, 0, 0));
        chk("reset_state_fast", obs_v, pk(3'd0, 0, 0, 0, 0, 0, 0));

        // Cycle 0: release reset with the PLL already locked
        rstnn             = 1'b1;
        dut_if.pll_locked = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            dut_if.pll_locked = tbl[i].pll;
            dut_if.sw_rst_req = tbl[i].req;
            step(1);
            dut_if.sw_rst_req = 1'b0;
            if (tbl[i].n > 1) step(tbl[i].n - 1);
            chk(tbl[i].nm, obs_m, tbl[i].exp);
        end
        chk_int("ack_count_table", ack_cnt, 2);

        // Asynchronous reset in the middle of a warm reset: no clock edge needed, lock_lost clears, no ack
        dut_if.sw_rst_req = 1'b1;
        step(1);
        dut_if.sw_rst_req = 1'b0;
        chk("sw_rst_before_arst", obs_m, pk(3'd5, 1, 0, 1, 0, 0, 1));
        step(2);
        #3;
        rstnn = 1'b0;
        #1;
        chk("async_reset_immediate", obs_m, pk(3'd0, 0, 0, 0, 0, 0, 0));
        step(10);
        chk("async_reset_held", obs_m, pk(3'd0, 0, 0, 0, 0, 0, 0));
        chk_int("no_ack_after_arst", ack_cnt, 2);

        // Lock glitch during STABLE: restart the count, no lock_lost
        rstnn             = 1'b1;
        dut_if.pll_locked = 1'b1;
        step(3);
        chk("glitch_stable_entry", obs_m, pk(3'd1, 0, 0, 0, 0, 0, 0));
        step(5);
        dut_if.pll_locked = 1'b0;
        step(2);
        chk("glitch_still_stable", obs_m, pk(3'd1, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("glitch_back_to_wait", obs_m, pk(3'd0, 0, 0, 0, 0, 0, 0));
        dut_if.pll_locked = 1'b1;
        step(2);
        chk("glitch_resync", obs_m, pk(3'd0, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("glitch_restable", obs_m, pk(3'd1, 0, 0, 0, 0, 0, 0));
        step(15);
        chk("glitch_full_count", obs_m, pk(3'd1, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("glitch_rel_dram", obs_m, pk(3'd2, 1, 0, 0, 0, 0, 0));

        // Minimal-delay instance: rstnn_system rises 6 edges after lock
        dut_if.pll_locked = 1'b0;
        rstnn = 1'b0;
        step(1);
        chk("fast_reset", obs_v, pk(3'd0, 0, 0, 0, 0, 0, 0));
        rstnn           = 1'b1;
        v_if.pll_locked = 1'b1;
        step(2);
        chk("fast_wait_sync", obs_v, pk(3'd0, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("fast_stable", obs_v, pk(3'd1, 0, 0, 0, 0, 0, 0));
        step(1);
        chk("fast_rel_dram", obs_v, pk(3'd2, 1, 0, 0, 0, 0, 0));
        step(1);
        chk("fast_rel_clk", obs_v, pk(3'd3, 1, 0, 1, 0, 0, 0));
        step(1);
        chk("fast_run", obs_v, pk(3'd4, 1, 1, 1, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
